// File: rtl/console_pkg.sv
// console_pkg: shared FSM states, register indexes and status bit positions for the console UART.
package console_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_e;
  localparam logic [6:0] CONSOLE_REG_DATA = 7'd0;
  localparam logic [6:0] CONSOLE_REG_STATUS = 7'd1;
  localparam int STAT_FULL = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY = 2;
  localparam int STAT_OVF = 3;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_MSB = 11;
endpackage

// File: rtl/console_fifo.sv
// console_fifo: synchronous 8-bit FIFO; a push while full is taken only when a pop frees a slot that cycle.
module console_fifo #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic full_o,
  output logic empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(do_push);
      rd_ptr_q <= rd_ptr_q + AW'(do_pop);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_ptr_q] <= wdata_i;
endmodule

// File: rtl/console_uart_ctrl.sv
// console_uart_ctrl: register-mapped console TX (data/status regs, FIFO, 8N1 serializer).
// Define CONSOLE_TX_PARITY_EN to insert an even-parity bit between data and stop.
module console_uart_ctrl
  import console_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic [6:0] register_index,
  input  logic register_read,
  input  logic register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  output logic uart_tx
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  tx_state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d, fifo_rdata;
  logic ovf_q, ovf_d;
  logic wr_data, wr_stat, pop, full, empty, baud_done;
  logic [CW-1:0] count;
  logic [15:0] status;
  logic unused_wdata;
  assign unused_wdata = ^register_write_value[15:8];
  assign wr_data = register_write && register_index == CONSOLE_REG_DATA;
  assign wr_stat = register_write && register_index == CONSOLE_REG_STATUS;
  assign pop = state_q == ST_IDLE && !empty;
  assign baud_done = baud_q == BW'(CLKS_PER_BIT - 1);
  console_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push_i(wr_data), .pop_i(pop), .wdata_i(register_write_value[7:0]),
    .rdata_o(fifo_rdata), .full_o(full), .empty_o(empty), .count_o(count)
  );
  always_comb begin
    state_d = state_q;
    baud_d = baud_q + 1'b1;
    bit_d = bit_q;
    data_d = data_q;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d = '0;
        if (pop) begin
          data_d = fifo_rdata;
          state_d = ST_START;
        end
      end
      ST_START: if (baud_done) begin
        baud_d = '0;
        state_d = ST_DATA;
      end
      ST_DATA: if (baud_done) begin
        baud_d = '0;
        bit_d = bit_q + 3'd1;
`ifdef CONSOLE_TX_PARITY_EN
        if (bit_q == 3'd7) state_d = ST_PARITY;
`else
        if (bit_q == 3'd7) state_d = ST_STOP;
`endif
      end
`ifdef CONSOLE_TX_PARITY_EN
      ST_PARITY: if (baud_done) begin
        baud_d = '0;
        state_d = ST_STOP;
      end
`endif
      ST_STOP: if (baud_done) begin
        baud_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // Set wins over a same-cycle software clear.
  assign ovf_d = (wr_data && full && !pop) ? 1'b1 : (wr_stat && register_write_value[STAT_OVF]) ? 1'b0 : ovf_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q <= '0;
      bit_q <= '0;
      data_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      data_q <= data_d;
      ovf_q <= ovf_d;
    end
  end
  always_comb begin
    status = '0;
    status[STAT_FULL] = full;
    status[STAT_EMPTY] = empty;
    status[STAT_BUSY] = state_q != ST_IDLE;
    status[STAT_OVF] = ovf_q;
    status[STAT_CNT_MSB:STAT_CNT_LSB] = 4'(count);
  end
  assign register_read_value = (register_read && register_index == CONSOLE_REG_STATUS) ? status : 16'h0000;
  assign uart_tx = state_q == ST_START ? 1'b0 :
                   state_q == ST_DATA ? data_q[bit_q] :
`ifdef CONSOLE_TX_PARITY_EN
                   state_q == ST_PARITY ? ^data_q :
`endif
                   1'b1;
endmodule

// File: tb/tb_console_uart_ctrl.sv
// tb_console_uart_ctrl: directed stimulus with a byte scoreboard checked by a negedge UART frame monitor.
module tb_console_uart_ctrl;
`ifdef CONSOLE_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] register_index = '0;
  logic register_read = 1'b0;
  logic register_write = 1'b0;
  logic [15:0] register_write_value = '0;
  logic [15:0] register_read_value;
  logic uart_tx;
  int checks = 0;
  int errors = 0;
  logic [7:0] q [$];
  logic mon_active = 1'b0;
  int mon_cnt = 0;
  int mon_frames = 0;
  logic [7:0] mon_byte = '0;
  int frames_before;
  console_uart_ctrl #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .register_index(register_index), .register_read(register_read),
    .register_write(register_write), .register_write_value(register_write_value),
    .register_read_value(register_read_value), .uart_tx(uart_tx)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [6:0] idx, input logic [15:0] val);
    register_index = idx;
    register_write_value = val;
    register_write = 1'b1;
    @(negedge clk);
    register_write = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [6:0] idx, input logic r, input logic [15:0] exp);
    register_index = idx;
    register_read = r;
    #1;
    chk(tag, register_read_value, exp);
    register_read = 1'b0;
  endtask
  task automatic drain(input int budget);
    int n = 0;
    while ((q.size() != 0 || mon_active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_budget", 16'(n < budget), 16'd1);
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (reset) mon_active = 1'b0;
    else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 2) chk("start_bit", {15'b0, uart_tx}, 16'd0);
      if (mon_cnt >= 6 && mon_cnt <= 34 && mon_cnt % 4 == 2) mon_byte[3'((mon_cnt - 6) / 4)] = uart_tx;
`ifdef CONSOLE_TX_PARITY_EN
      if (mon_cnt == 38) chk("parity_bit", {15'b0, uart_tx}, {15'b0, ^mon_byte});
`endif
      if (mon_cnt == 4 * NB - 2) chk("stop_bit", {15'b0, uart_tx}, 16'd1);
      if (mon_cnt == 4 * NB - 1) begin
        mon_active = 1'b0;
        mon_frames++;
        chk("frame_expected", 16'(q.size() != 0), 16'd1);
        if (q.size() != 0) chk("rx_byte", {8'h00, mon_byte}, {8'h00, q.pop_front()});
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_tx", {15'b0, uart_tx}, 16'd1);
    rd("reset_status", 7'd1, 1'b1, 16'h0002);
    rd("reset_rdval_gated", 7'd1, 1'b0, 16'h0000);
    // single byte latency and frame shape
    wr(7'd0, 16'hA541);
    q.push_back(8'h41);
    chk("tx_idle_after_push", {15'b0, uart_tx}, 16'd1);
    rd("status_after_push", 7'd1, 1'b1, 16'h0100);
    @(negedge clk);
    chk("tx_start_latency", {15'b0, uart_tx}, 16'd0);
    rd("status_after_pop", 7'd1, 1'b1, 16'h0006);
    repeat (3) @(negedge clk);
    chk("tx_start_last", {15'b0, uart_tx}, 16'd0);
    @(negedge clk);
    chk("tx_bit0", {15'b0, uart_tx}, 16'd1);
    drain(200);
    rd("status_idle", 7'd1, 1'b1, 16'h0002);
    // nine back-to-back writes, then an overflowing tenth
    for (int i = 0; i < 9; i++) begin
      wr(7'd0, 16'(8'h30 + i));
      q.push_back(8'(8'h30 + i));
    end
    rd("status_full", 7'd1, 1'b1, 16'h0805);
    wr(7'd0, 16'h0039);
    rd("status_overflow", 7'd1, 1'b1, 16'h080D);
    wr(7'd1, 16'h0008);
    rd("status_ovf_cleared", 7'd1, 1'b1, 16'h0805);
    drain(1000);
    rd("status_after_drain", 7'd1, 1'b1, 16'h0002);
    // reset mid-frame with bytes queued
    wr(7'd0, 16'h0011);
    wr(7'd0, 16'h0022);
    wr(7'd0, 16'h0033);
    q.push_back(8'h11);
    q.push_back(8'h22);
    q.push_back(8'h33);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("tx_high_after_reset", {15'b0, uart_tx}, 16'd1);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    rd("status_after_reset", 7'd1, 1'b1, 16'h0002);
    frames_before = mon_frames;
    repeat (100) @(negedge clk);
    chk("no_frames_after_reset", 16'(mon_frames), 16'(frames_before));
    chk("tx_idle_after_reset", {15'b0, uart_tx}, 16'd1);
    // unmapped indexes and read gating
    rd("read_index5", 7'd5, 1'b1, 16'h0000);
    rd("read_index0", 7'd0, 1'b1, 16'h0000);
    wr(7'd2, 16'h00FF);
    rd("status_after_idx2_write", 7'd1, 1'b1, 16'h0002);
    @(negedge clk);
    chk("tx_after_idx2_write", {15'b0, uart_tx}, 16'd1);
    rd("status_read_low", 7'd1, 1'b0, 16'h0000);
    // back-to-back frames: one idle cycle between stop and next start
    wr(7'd0, 16'h0055);
    wr(7'd0, 16'h00AA);
    q.push_back(8'h55);
    q.push_back(8'hAA);
    repeat (4 * NB - 1) @(negedge clk);
    chk("last_stop_cycle", {15'b0, uart_tx}, 16'd1);
    rd("busy_in_stop", 7'd1, 1'b1, 16'h0104);
    @(negedge clk);
    chk("idle_gap_tx", {15'b0, uart_tx}, 16'd1);
    rd("idle_gap_status", 7'd1, 1'b1, 16'h0100);
    @(negedge clk);
    chk("second_start", {15'b0, uart_tx}, 16'd0);
    rd("second_busy", 7'd1, 1'b1, 16'h0006);
    drain(200);
    rd("final_status", 7'd1, 1'b1, 16'h0002);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/console_uart_ctrl.md
# console_uart_ctrl

Console output controller on the core's I/O register bus. It claims register indexes 0 (data) and 1 (status/control). Bytes written to index 0 are buffered in a small FIFO and drained out as 8N1 UART frames on `uart_tx`. Status is readable by software, so programs can poll before writing instead of losing characters.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; must be ≥ 2.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, 2..8.
- `clk` in 1: the single clock; everything is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `register_index` in 7: register select from the core.
- `register_read` in 1: read strobe.
- `register_write` in 1: write strobe; one transfer per cycle it is high.
- `register_write_value` in 16: write data.
- `register_read_value` out 16: read data.
- `uart_tx` out 1: serial line; idle high.

## Operation
- Index 0, write: bits [7:0] are pushed into the FIFO; bits [15:8] are ignored.
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and sticky `overflow` is set.
  - A push while full is accepted if a pop happens in that same cycle.
- Index 0, read: returns 0.
- Index 1, read returns the status word:
  - bit0 `full`, bit1 `empty`, bit2 `busy` (FSM not IDLE), bit3 `overflow`.
  - bits [11:8] FIFO count; all other bits 0.
- Index 1, write: writing 1 to bit3 clears `overflow`; all other bits ignored. If set and clear happen in the same cycle, set wins.
- Any other index: writes are ignored and reads return 0.
- `register_read_value` is combinational from registered state and `register_index`. It is gated to 0 when `register_read` is low.
- TX FSM states:
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to START.
  - START: `uart_tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
  - DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles; a 3-bit bit counter runs 0..7 and the transition to STOP happens at 7 (no wrap).
  - PARITY: optional, see Configuration.
  - STOP: `uart_tx`=1 for `CLKS_PER_BIT` cycles, then IDLE.
- The baud counter is `$clog2(CLKS_PER_BIT)` bits wide. It reloads to 0 on every state or bit change and terminates at `CLKS_PER_BIT-1`.
- Reset values:
  - `uart_tx`=1; FSM IDLE.
  - FIFO empty with pointers 0; count 0; `overflow`=0.
  - `register_read_value`=0.
- Reset mid-frame aborts the frame: `uart_tx` is high from the cycle after the reset edge, and all FIFO contents are discarded.

## Timing
- A write to index 0 at edge N makes count/`empty` reflect the new entry after edge N.
- With FSM IDLE, the pop occurs at edge N+1 and `uart_tx` falls after edge N+1, i.e. 2-cycle latency from the write strobe to the start bit.
- Frame length is 10×`CLKS_PER_BIT` cycles, or 11× with parity.
- Back-to-back frames have exactly one cycle of IDLE (`uart_tx`=1) between the stop bit and the next start bit.
- The status count is updated on the same edge as a push or pop. Simultaneous push and pop leave the count unchanged.
- No wait states: every bus access completes in the cycle it is presented.

## Configuration
- `CONSOLE_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

## Structure
- Package `console_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - `CONSOLE_REG_DATA`=0 and `CONSOLE_REG_STATUS`=1;
  - status bit positions `STAT_FULL`=0, `STAT_EMPTY`=1, `STAT_BUSY`=2, `STAT_OVF`=3, and count field [11:8].
- Sub-module `console_fifo`: synchronous 8-bit-wide FIFO with push/pop/full/empty/count. Pointer wrap is by natural overflow of `$clog2(FIFO_DEPTH)`-bit pointers.
- Top level contains the register decode, the overflow flag and the TX FSM.

## Test plan
Benches use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=8.
- Write 0x0041 to index 0 from reset.
  - `uart_tx` low 2 cycles after the strobe, for 4 cycles.
  - Then data 1,0,0,0,0,0,1,0 at 4 cycles each, then high for 4 cycles.
  - With parity enabled, parity bit 0 precedes stop.
- Write 9 bytes on consecutive cycles while idle.
  - First byte popped at the 2nd cycle; all 8 remaining are accepted; `overflow`=1 is reached only if a 10th write is issued before a pop frees space.
  - Status read shows count and `full` consistent with the pops performed.
- Fill the FIFO (8 entries, hold TX by writing during reset release), then write once more.
  - Byte dropped; status = 0x0809 with `busy` per FSM state.
  - Writing 0x0008 to index 1 clears bit3.
- Assert `reset` mid-DATA with 3 bytes queued.
  - `uart_tx`=1 the next cycle; status reads count 0, `empty`=1, `overflow`=0; no further frames are sent.
- Read index 5, and write 0x00FF to index 2.
  - Read returns 0; FIFO and `uart_tx` are unaffected.
  - Read of index 1 with `register_read`=0 returns 0.
- Two queued bytes 0x55, 0xAA: exactly one idle-high cycle between the first stop bit and the second start bit.
